spi_flash_responder: RTL and testbench

Synthesizable SPI-flash responder that acts as the device end of the platform's SPI flash link (SPIFlashCEJ/SCK/SI/SO/WPJ). It oversamples the master's pins on the system clock, decodes a subset of the standard serial-flash command set, and serves reads and page programs from an internal byte array. It stands in for the external flash in simulation and in loop-back FPGA builds.

---
 rtl/spi_flash_responder.sv | 184 ++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_flash_responder: oversampled SPI-flash device model serving RDID,  |
// | RDSR, WREN, WRDI, READ and PP from an internal byte array.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module spi_flash_responder #(
  parameter int          ADDR_W   = 10,
  parameter logic [23:0] JEDEC_ID = 24'hC22015
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SPIFlashCEJ,
  input  logic       SPIFlashSCK,
  input  logic       SPIFlashSI,
  output logic       SPIFlashSO,
  input  logic       SPIFlashWPJ,
  output logic       wel,
  output logic [7:0] last_cmd
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DOUT, S_DIN, S_IGNORE} state_t;
  typedef enum logic [1:0] {SRC_ID, SRC_SR, SRC_MEM} src_t;

  state_t              r_state;
  src_t                r_src;
  logic [1:0]          r_sck_s, r_cej_s, r_si_s, r_wpj_s;
  logic                r_sck_d, r_cej_d;
  logic [4:0]          r_bit_cnt;
  logic [6:0]          r_shift;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_page_off;
  logic [7:0]          r_out;
  logic [1:0]          r_id_idx;
  logic                r_is_read, r_extra, r_pp_any;
  logic [7:0]          r_mem [2**ADDR_W];

  logic                w_sck_rise, w_sck_fall, w_cej_hi, w_cej_rise, w_si, w_wpj;
  logic [7:0]          w_rx_byte, w_dout_byte, w_page_lo;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;

  assign w_sck_rise  = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s[1] & r_sck_d;
  assign w_cej_hi    = r_cej_s[1];
  assign w_cej_rise  = r_cej_s[1] & ~r_cej_d;
  assign w_si        = r_si_s[1];
  assign w_wpj       = r_wpj_s[1];
  assign w_rx_byte   = {r_shift, w_si};
  assign w_page_lo   = r_addr[7:0] + r_page_off;
  assign w_mem_waddr = {r_addr[ADDR_W-1:8], w_page_lo};
  // CEJ rise has priority over a coincident SCK edge, so gate the write too
  assign w_mem_we    = (r_state == S_DIN) && w_sck_rise && !w_cej_hi &&
                       (r_bit_cnt == 5'd7) && wel && w_wpj;

  always_comb begin
    w_dout_byte = 8'h00;
    case (r_src)
      SRC_ID: begin
        case (r_id_idx)
          2'd2:    w_dout_byte = JEDEC_ID[23:16];
          2'd1:    w_dout_byte = JEDEC_ID[15:8];
          default: w_dout_byte = JEDEC_ID[7:0];
        endcase
      end
      SRC_SR:  w_dout_byte = {6'b0, wel, 1'b0};
      default: w_dout_byte = r_mem[r_addr];
    endcase
  end

  // Array deliberately has no reset
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_rx_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_s    <= 2'b00;
      r_cej_s    <= 2'b11;
      r_si_s     <= 2'b00;
      r_wpj_s    <= 2'b11;
      r_sck_d    <= 1'b0;
      r_cej_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_src      <= SRC_ID;
      r_bit_cnt  <= 5'd0;
      r_shift    <= 7'd0;
      r_addr     <= '0;
      r_page_off <= 8'd0;
      r_out      <= 8'd0;
      r_id_idx   <= 2'd2;
      r_is_read  <= 1'b0;
      r_extra    <= 1'b0;
      r_pp_any   <= 1'b0;
      SPIFlashSO <= 1'b0;
      wel        <= 1'b0;
      last_cmd   <= 8'h00;
    end else begin
      r_sck_s <= {r_sck_s[0], SPIFlashSCK};
      r_cej_s <= {r_cej_s[0], SPIFlashCEJ};
      r_si_s  <= {r_si_s[0], SPIFlashSI};
      r_wpj_s <= {r_wpj_s[0], SPIFlashWPJ};
      r_sck_d <= r_sck_s[1];
      r_cej_d <= r_cej_s[1];

      if (w_cej_hi) begin
        r_state    <= S_IDLE;
        r_bit_cnt  <= 5'd0;
        r_page_off <= 8'd0;
        r_extra    <= 1'b0;
        r_pp_any   <= 1'b0;
        SPIFlashSO <= 1'b0;
        if (w_cej_rise) begin
          // WREN/WRDI only count when exactly eight bits were clocked
          if (r_state == S_IGNORE && !r_extra && last_cmd == 8'h06) wel <= 1'b1;
          if (r_state == S_IGNORE && !r_extra && last_cmd == 8'h04) wel <= 1'b0;
          if (r_pp_any) wel <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_CMD;
          S_CMD: if (w_sck_rise) begin
            r_shift   <= w_rx_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt <= 5'd0;
              last_cmd  <= w_rx_byte;
              case (w_rx_byte)
                8'h9F:   begin r_state <= S_DOUT; r_src <= SRC_ID; r_id_idx <= 2'd2; end
                8'h05:   begin r_state <= S_DOUT; r_src <= SRC_SR; end
                8'h03:   begin r_state <= S_ADDR; r_is_read <= 1'b1; end
                8'h02:   begin r_state <= S_ADDR; r_is_read <= 1'b0; end
                default: r_state <= S_IGNORE;
              endcase
            end
          end
          S_ADDR: if (w_sck_rise) begin
            r_addr    <= {r_addr[ADDR_W-2:0], w_si};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              r_bit_cnt <= 5'd0;
              r_src     <= SRC_MEM;
              r_state   <= r_is_read ? S_DOUT : S_DIN;
            end
          end
          S_DOUT: begin
            if (w_sck_fall) begin
              if (r_bit_cnt == 5'd0) begin
                SPIFlashSO <= w_dout_byte[7];
                r_out      <= {w_dout_byte[6:0], 1'b0};
              end else begin
                SPIFlashSO <= r_out[7];
                r_out      <= {r_out[6:0], 1'b0};
              end
            end
            if (w_sck_rise) begin
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= 5'd0;
                r_addr    <= r_addr + 1'b1;
                r_id_idx  <= (r_id_idx == 2'd0) ? 2'd2 : r_id_idx - 2'd1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          S_DIN: if (w_sck_rise) begin
            r_shift <= w_rx_byte[6:0];
            if (r_bit_cnt == 5'd7) begin
              r_bit_cnt  <= 5'd0;
              r_page_off <= r_page_off + 8'd1;
              r_pp_any   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
          S_IGNORE: if (w_sck_rise) r_extra <= 1'b1;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// Directed bench for spi_flash_responder: SPI mode-0 master driven from tasks,
// hand-computed expected bytes checked inline.
module tb_spi_flash_responder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cej = 1'b1, sck = 1'b0, si = 1'b0, wpj = 1'b1;
  logic       so, wel;
  logic [7:0] last_cmd;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_W(10), .JEDEC_ID(24'hC22015)) dut (
    .clk(clk), .reset_n(reset_n), .SPIFlashCEJ(cej), .SPIFlashSCK(sck),
    .SPIFlashSI(si), .SPIFlashSO(so), .SPIFlashWPJ(wpj), .wel(wel), .last_cmd(last_cmd)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    si = b;
    tick(6);
    r = so;
    sck = 1'b1;
    tick(6);
    sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_low();
    sck = 1'b0;
    cej = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(6);
    cej = 1'b1;
    tick(8);
  endtask

  task automatic cmd_only(input logic [7:0] op);
    logic [7:0] d;
    cs_low();
    xfer_byte(op, d);
    cs_high();
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] d;
    xfer_byte(a[23:16], d);
    xfer_byte(a[15:8], d);
    xfer_byte(a[7:0], d);
  endtask

  task automatic do_pp(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1,
                       input int n);
    logic [7:0] d;
    cs_low();
    xfer_byte(8'h02, d);
    send_addr(a);
    xfer_byte(d0, d);
    if (n > 1) xfer_byte(d1, d);
    cs_high();
  endtask

  task automatic do_read(input logic [23:0] a, output logic [7:0] b0, output logic [7:0] b1);
    cs_low();
    xfer_byte(8'h03, b0);
    send_addr(a);
    xfer_byte(8'h00, b0);
    xfer_byte(8'h00, b1);
    cs_high();
  endtask

  task automatic do_rdsr(output logic [7:0] b0, output logic [7:0] b1);
    cs_low();
    xfer_byte(8'h05, b0);
    xfer_byte(8'h00, b0);
    xfer_byte(8'h00, b1);
    cs_high();
  endtask

  task automatic test_reset();
    n_checks += 3;
    if (so !== 1'b0) begin n_fail++; $display("FAIL reset_so: got %b expected 0", so); end
    if (wel !== 1'b0) begin n_fail++; $display("FAIL reset_wel: got %b expected 0", wel); end
    if (last_cmd !== 8'h00) begin n_fail++; $display("FAIL reset_last_cmd: got %h expected 00", last_cmd); end
  endtask

  task automatic test_rdsr();
    logic [7:0] b0, b1;
    do_rdsr(b0, b1);
    n_checks += 4;
    if (b0 !== 8'h00) begin n_fail++; $display("FAIL rdsr_b0: got %h expected 00", b0); end
    if (b1 !== 8'h00) begin n_fail++; $display("FAIL rdsr_b1: got %h expected 00", b1); end
    if (wel !== 1'b0) begin n_fail++; $display("FAIL rdsr_wel: got %b expected 0", wel); end
    if (last_cmd !== 8'h05) begin n_fail++; $display("FAIL rdsr_last_cmd: got %h expected 05", last_cmd); end
  endtask

  task automatic test_rdid();
    logic [7:0] exp_id [4];
    logic [7:0] d;
    exp_id = '{8'hC2, 8'h20, 8'h15, 8'hC2};
    cs_low();
    xfer_byte(8'h9F, d);
    for (int i = 0; i < 4; i++) begin
      xfer_byte(8'h00, d);
      n_checks++;
      if (d !== exp_id[i]) begin n_fail++; $display("FAIL rdid_byte%0d: got %h expected %h", i, d, exp_id[i]); end
    end
    cs_high();
    n_checks++;
    if (last_cmd !== 8'h9F) begin n_fail++; $display("FAIL rdid_last_cmd: got %h expected 9f", last_cmd); end
  endtask

  task automatic test_pp_read();
    logic [7:0] b0, b1;
    cmd_only(8'h06);
    n_checks++;
    if (wel !== 1'b1) begin n_fail++; $display("FAIL wren_wel: got %b expected 1", wel); end
    do_rdsr(b0, b1);
    n_checks += 2;
    if (b0 !== 8'h02) begin n_fail++; $display("FAIL rdsr_wel_b0: got %h expected 02", b0); end
    if (b1 !== 8'h02) begin n_fail++; $display("FAIL rdsr_wel_b1: got %h expected 02", b1); end
    do_pp(24'h000010, 8'hA5, 8'h5A, 2);
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL pp_clears_wel: got %b expected 0", wel); end
    do_read(24'h000010, b0, b1);
    n_checks += 2;
    if (b0 !== 8'hA5) begin n_fail++; $display("FAIL read10_b0: got %h expected a5", b0); end
    if (b1 !== 8'h5A) begin n_fail++; $display("FAIL read10_b1: got %h expected 5a", b1); end
    do_rdsr(b0, b1);
    n_checks++;
    if (b0 !== 8'h00) begin n_fail++; $display("FAIL rdsr_after_pp: got %h expected 00", b0); end
    do_read(24'hFFFC10, b0, b1);
    n_checks++;
    if (b0 !== 8'hA5) begin n_fail++; $display("FAIL read_upper_addr: got %h expected a5", b0); end
  endtask

  task automatic test_write_protect();
    logic [7:0] b0, b1;
    cmd_only(8'h06);
    do_pp(24'h000020, 8'h00, 8'h00, 1);
    cmd_only(8'h06);
    wpj = 1'b0;
    do_pp(24'h000020, 8'h33, 8'h00, 1);
    wpj = 1'b1;
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL wp_wel: got %b expected 0", wel); end
    do_read(24'h000020, b0, b1);
    n_checks++;
    if (b0 !== 8'h00) begin n_fail++; $display("FAIL wp_read: got %h expected 00", b0); end
  endtask

  task automatic test_wrap();
    logic [7:0] b0, b1;
    cmd_only(8'h06);
    do_pp(24'h0003FF, 8'h77, 8'h00, 1);
    cmd_only(8'h06);
    do_pp(24'h0000FF, 8'h11, 8'h22, 2);
    do_read(24'h0000FF, b0, b1);
    n_checks++;
    if (b0 !== 8'h11) begin n_fail++; $display("FAIL wrap_read_ff: got %h expected 11", b0); end
    do_read(24'h0003FF, b0, b1);
    n_checks += 2;
    if (b0 !== 8'h77) begin n_fail++; $display("FAIL wrap_read_3ff: got %h expected 77", b0); end
    if (b1 !== 8'h22) begin n_fail++; $display("FAIL wrap_read_000: got %h expected 22", b1); end
  endtask

  task automatic test_abort();
    logic [7:0] d, b1;
    logic       b;
    cmd_only(8'h06);
    cs_low();
    xfer_byte(8'h02, d);
    for (int i = 0; i < 12; i++) xfer_bit(1'b0, b);
    cs_high();
    n_checks++;
    if (wel !== 1'b1) begin n_fail++; $display("FAIL abort_addr_wel: got %b expected 1", wel); end
    cs_low();
    xfer_byte(8'h02, d);
    send_addr(24'h000010);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, b);
    cs_high();
    n_checks++;
    if (wel !== 1'b1) begin n_fail++; $display("FAIL abort_data_wel: got %b expected 1", wel); end
    do_read(24'h000010, d, b1);
    n_checks++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL abort_no_write: got %h expected a5", d); end
    cs_low();
    xfer_byte(8'h9F, d);
    tick(5);
    n_checks++;
    if (so !== 1'b1) begin n_fail++; $display("FAIL dout_msb: got %b expected 1", so); end
    cej = 1'b1;
    tick(3);
    n_checks++;
    if (so !== 1'b0) begin n_fail++; $display("FAIL abort_so: got %b expected 0", so); end
    tick(8);
    cmd_only(8'h04);
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL wrdi_wel: got %b expected 0", wel); end
    cs_low();
    for (int i = 7; i >= 1; i--) xfer_bit((i == 2 || i == 1), b);
    cs_high();
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL wren7_wel: got %b expected 0", wel); end
    cs_low();
    xfer_byte(8'h06, d);
    xfer_bit(1'b0, b);
    cs_high();
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL wren9_wel: got %b expected 0", wel); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d, b1;
    logic       b;
    cmd_only(8'h06);
    cs_low();
    for (int i = 0; i < 4; i++) xfer_bit(1'b1, b);
    reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL async_rst_wel: got %b expected 0", wel); end
    if (last_cmd !== 8'h00) begin n_fail++; $display("FAIL async_rst_cmd: got %h expected 00", last_cmd); end
    if (so !== 1'b0) begin n_fail++; $display("FAIL async_rst_so: got %b expected 0", so); end
    tick(2);
    cej = 1'b1;
    reset_n = 1'b1;
    tick(8);
    do_read(24'h000010, d, b1);
    n_checks++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL async_rst_array: got %h expected a5", d); end
  endtask

  initial begin
    tick(3);
    test_reset();
    reset_n = 1'b1;
    tick(4);
    test_rdsr();
    test_rdid();
    test_pp_read();
    test_write_protect();
    test_wrap();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
